// File: rtl/slt_pkg.sv
// Shared definitions for the bit-serial set-less-than unit: FSM encodings and
// the subtract carry-in.
package slt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // a - b is formed as a + ~b + 1, so the first slice sees carry-in 1.
  localparam logic SubCarryIn = 1'b1;

endpackage

// File: rtl/slt_bit_slice.sv
// One-bit full adder with the B operand inverted, i.e. a single subtract slice.
module slt_bit_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_nb;

  assign w_nb = ~b;
  assign sum  = a ^ w_nb ^ cin;
  assign cout = (a & w_nb) | (a & cin) | (w_nb & cin);

endmodule

// File: rtl/serial_slt.sv
// Bit-serial signed a < b: one subtract slice per cycle, LSB first, W cycles per compare.
// Define SERIAL_SLT_DIFF_EN to also expose the full a - b difference on port diff.
module serial_slt
  import slt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         slt,
  output logic         overflow,
  output logic         busy
`ifdef SERIAL_SLT_DIFF_EN
  ,
  output logic [W-1:0] diff
`endif
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  state_e         r_state;
  state_e         w_state_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [CntW-1:0] r_cnt;
  logic           r_slt;
  logic           r_ovf;
  logic           w_sum;
  logic           w_cout;
  logic           w_accept;
  logic           w_run;
  logic           w_last;

  slt_bit_slice u_slice (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .sum (w_sum),
    .cout(w_cout)
  );

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_run    = (r_state == StRun);
  assign w_last   = (r_cnt == CntW'(W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = StRun;
      end
      StRun: begin
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_slt   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= SubCarryIn;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CntW'(1);
      // Sign bit: true sign of a - b is the raw sum bit corrected by overflow.
      if (w_last) begin
        r_ovf <= r_carry ^ w_cout;
        r_slt <= w_sum ^ (r_carry ^ w_cout);
      end
    end
  end

  assign slt      = r_slt;
  assign overflow = r_ovf;

`ifdef SERIAL_SLT_DIFF_EN
  logic [W-1:0] r_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_diff <= '0;
    end else if (w_run) begin
      r_diff <= {w_sum, r_diff[W-1:1]};
    end
  end

  assign diff = r_diff;
`endif

endmodule

// File: tb/tb_serial_slt.sv
// Self-checking bench for serial_slt: transaction-level model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_slt;

  localparam int W = 4;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         slt;
  logic         overflow;
  logic         busy;
`ifdef SERIAL_SLT_DIFF_EN
  logic [W-1:0] diff;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  serial_slt #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .slt      (slt),
    .overflow (overflow),
    .busy     (busy)
`ifdef SERIAL_SLT_DIFF_EN
    ,
    .diff     (diff)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic: plain signed integers, no bit-serial modelling.
  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = sx(x) - sx(y);
    return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
  endfunction

  // Transaction model: busy from accept until drained, result visible W cycles after accept.
  logic         m_busy = 1'b0;
  int           m_age  = 0;
  logic         m_slt  = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         e_slt  = 1'b0;
  logic         e_ovf  = 1'b0;
  logic [W-1:0] e_diff = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_slt  <= 1'b0;
      m_ovf  <= 1'b0;
      m_diff <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        e_slt  <= (sx(a) < sx(b));
        e_ovf  <= ovf_of(a, b);
        e_diff <= a - b;
      end
    end else if (m_age < W) begin
      m_age <= m_age + 1;
      if (m_age == W - 1) begin
        m_slt  <= e_slt;
        m_ovf  <= e_ovf;
        m_diff <= e_diff;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, m_busy && (m_age == W));
      check("busy", busy, m_busy);
      check("slt", slt, m_slt);
      check("overflow", overflow, m_ovf);
`ifdef SERIAL_SLT_DIFF_EN
      if (out_valid) check("diff", diff, m_diff);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 3 * W) begin
      tick();
      n++;
    end
  endtask

  task automatic run_pair(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic es, input logic eo, input logic [W-1:0] ed);
    int n;
    a = ta;
    b = tb_v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("lit_latency", n, W);
    check("lit_slt", slt, es);
    check("lit_overflow", overflow, eo);
`ifdef SERIAL_SLT_DIFF_EN
    check("lit_diff", diff, ed);
`else
    if (ed === 'x) check("lit_diff_arg", 1'b0, 1'b1);
`endif
    tick();
  endtask

  logic [W-1:0] pa[3];
  logic [W-1:0] pb[3];
  logic         ps[3];
  int           acc[3];

  initial begin
    int n;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_slt", slt, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    chk_en = 1'b1;
    #2 reset = 1'b0;
    tick();

    run_pair(4'd3, 4'd5, 1'b1, 1'b0, 4'b1110);
    run_pair(4'b1000, 4'd1, 1'b1, 1'b1, 4'b0111);
    run_pair(4'd7, 4'b1111, 1'b0, 1'b1, 4'b1000);
    run_pair(4'd5, 4'd5, 1'b0, 1'b0, 4'b0000);
    run_pair(4'b1101, 4'b1101, 1'b0, 1'b0, 4'b0000);

    // Backpressure: result held, new operands refused until drained.
    a = 4'd2;
    b = 4'd6;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    a = 4'd7;
    b = 4'd1;
    wait_out(n);
    check("bp_latency", n, W);
    repeat (3) begin
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_slt", slt, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", in_ready, 1'b1);
    check("bp_idle_valid", out_valid, 1'b0);
    tick();
    check("bp_new_accept", busy, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    check("bp_new_slt", slt, 1'b0);
    check("bp_new_ovf", overflow, 1'b0);
    tick();

    // Asynchronous reset two cycles into RUN.
    run_pair(4'd0, 4'd1, 1'b1, 1'b0, 4'b1111);
    a = 4'd3;
    b = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_slt", slt, 1'b0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    run_pair(4'd1, 4'd0, 1'b0, 1'b0, 4'b0001);

    // Back-to-back with in_valid held high.
    pa = '{4'd0, 4'd1, 4'b1111};
    pb = '{4'd1, 4'd0, 4'd0};
    ps = '{1'b1, 1'b0, 1'b1};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = pa[i];
      b = pb[i];
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
      acc[i] = cyc;
      wait_out(n);
      check("b2b_slt", slt, ps[i]);
    end
    in_valid = 1'b0;
    check("b2b_gap01", acc[1] - acc[0], W + 2);
    check("b2b_gap12", acc[2] - acc[1], W + 2);
    tick();

    // Randomized traffic against the model, biased toward equal and extreme operands.
    for (int c = 0; c < 1500; c++) begin
      int sel;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      a = W'($urandom);
      b = W'($urandom);
      if (sel == 0) b = a;
      if (sel == 1) a = {1'b1, {(W - 1){1'b0}}};
      if (sel == 2) b = {1'b0, {(W - 1){1'b1}}};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3 * W) tick();
    check("final_idle", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
